// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cook_timer_ctrl
// Purpose  : Microwave cook-cycle controller. Builds an M:SS BCD cook time
//            from keypad digits, counts it down on a 1 Hz tick, handles
//            door/stop pauses and holds a done indication for a few seconds.
// Revision : 1.0 - initial release
// ============================================================================
module cook_timer_ctrl #(
  parameter int DONE_TICKS = 3,
  parameter int DONE_W     = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       tick_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enc_enable,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Hold-counter value seen on the tick that ends the done display.
  localparam logic [DONE_W-1:0] C_HOLD_LAST = DONE_W'(DONE_TICKS - 1);

  state_t            state_q, state_d;
  logic [3:0]        min_q, min_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic [DONE_W-1:0] hold_q, hold_d;
  logic              loadn_q, startn_q, stopn_q;
  logic              enc_q, enc_d;
  logic              mag_q, mag_d;
  logic              done_q, done_d;

  // Falling-edge events on the active-low inputs.
  logic key_ev, start_ev, stop_ev, key_ok, time_nz;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic dec_zero;

  assign key_ev   = loadn_q & ~loadn;
  assign start_ev = startn_q & ~startn;
  assign stop_ev  = stopn_q & ~stopn;
  assign key_ok   = key_ev && (D <= 4'd9);
  assign time_nz  = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);

  // One-second BCD decrement with borrow from tens and then minutes.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_q != 4'd0) begin
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
    dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  // Next-state, digit and output decode; stop beats start, start beats key.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (key_ok && !start_ev && !stop_ev) begin
          min_d   = tens_q;
          tens_d  = ones_q;
          ones_d  = D;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop_ev) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = ST_IDLE;
        end else if (start_ev) begin
          // A rejected start still swallows any key in the same cycle.
          if (time_nz && door_closed) begin
            state_d = ST_COOK;
          end
        end else if (key_ok) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = D;
        end
      end
      ST_COOK: begin
        if (stop_ev || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick_1hz) begin
          min_d  = dec_min;
          tens_d = dec_tens;
          ones_d = dec_ones;
          if (dec_zero) begin
            hold_d  = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = ST_IDLE;
        end else if (start_ev && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        min_d  = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
        if (start_ev || stop_ev) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if (tick_1hz) begin
          if (hold_q == C_HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + DONE_W'(1);
          end
        end
      end
      default: begin
        min_d   = 4'd0;
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    enc_d  = (state_d == ST_IDLE) || (state_d == ST_ENTRY);
    mag_d  = (state_d == ST_COOK);
    done_d = (state_d == ST_DONE);
  end

  // State, digits, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      min_q    <= 4'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      hold_q   <= '0;
      loadn_q  <= 1'b1;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      enc_q    <= 1'b1;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      hold_q   <= hold_d;
      loadn_q  <= loadn;
      startn_q <= startn;
      stopn_q  <= stopn;
      enc_q    <= enc_d;
      mag_q    <= mag_d;
      done_q   <= done_d;
    end
  end

  assign enc_enable = enc_q;
  assign min_ones   = min_q;
  assign sec_tens   = tens_q;
  assign sec_ones   = ones_q;
  assign mag_on     = mag_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cook_timer_ctrl
// Purpose  : Directed self-checking bench for cook_timer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       door_closed = 1'b1;
  logic       enc_enable, mag_on, done;
  logic [3:0] min_ones, sec_tens, sec_ones;

  int total = 0;
  int bad = 0;

  cook_timer_ctrl #(.DONE_TICKS(3), .DONE_W(2)) dut (
    .clk(clk), .clear(clear), .D(D), .loadn(loadn), .tick_1hz(tick_1hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .enc_enable(enc_enable), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] digits();
    return {20'd0, min_ones, sec_tens, sec_ones};
  endfunction

  // Key held low for three cycles must shift only once.
  task automatic key(input logic [3:0] d);
    D = d; loadn = 1'b0;
    step(); step(); step();
    loadn = 1'b1;
    step();
  endtask

  task automatic press_start();
    startn = 1'b0; step(); startn = 1'b1; step();
  endtask

  task automatic press_stop();
    stopn = 1'b0; step(); stopn = 1'b1; step();
  endtask

  task automatic tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
  endtask

  initial begin
    // 1: reset and digit entry
    clear = 1'b1; step(); step();
    clear = 1'b0;
    chk("rst_digits", digits(), 32'h000);
    chk("rst_enc", {31'd0, enc_enable}, 32'd1);
    chk("rst_mag", {31'd0, mag_on}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_130", digits(), 32'h130);
    chk("entry_enc", {31'd0, enc_enable}, 32'd1);
    press_stop();
    chk("entry_stop", digits(), 32'h000);

    // 2: 0:02 countdown into done and back to idle
    door_closed = 1'b1;
    key(4'd0); key(4'd0); key(4'd2);
    chk("t2_digits", digits(), 32'h002);
    startn = 1'b0; step();
    chk("t2_mag_on", {31'd0, mag_on}, 32'd1);
    chk("t2_enc_off", {31'd0, enc_enable}, 32'd0);
    startn = 1'b1; step();
    tick();
    chk("t2_tick1", digits(), 32'h001);
    chk("t2_tick1_mag", {31'd0, mag_on}, 32'd1);
    tick();
    chk("t2_zero", digits(), 32'h000);
    chk("t2_zero_mag", {31'd0, mag_on}, 32'd0);
    chk("t2_done", {31'd0, done}, 32'd1);
    tick(); tick();
    chk("t2_done_hold", {31'd0, done}, 32'd1);
    tick();
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    chk("t2_idle_enc", {31'd0, enc_enable}, 32'd1);

    // 3: minute borrow and door pause
    key(4'd1); key(4'd0); key(4'd0);
    press_start();
    chk("t3_cook", {31'd0, mag_on}, 32'd1);
    tick();
    chk("t3_borrow", digits(), 32'h059);
    door_closed = 1'b0; step();
    chk("t3_pause_mag", {31'd0, mag_on}, 32'd0);
    tick(); tick();
    chk("t3_pause_hold", digits(), 32'h059);
    door_closed = 1'b1;
    press_start();
    chk("t3_resume", {31'd0, mag_on}, 32'd1);
    chk("t3_resume_dig", digits(), 32'h059);
    press_stop();
    chk("t3_to_pause", {31'd0, mag_on}, 32'd0);
    press_stop();
    chk("t3_cancel", digits(), 32'h000);
    chk("t3_cancel_enc", {31'd0, enc_enable}, 32'd1);

    // 4: rejected starts
    key(4'd0);
    press_start();
    chk("t4_zero_start", {31'd0, mag_on}, 32'd0);
    chk("t4_zero_enc", {31'd0, enc_enable}, 32'd1);
    key(4'd0); key(4'd5);
    chk("t4_digits", digits(), 32'h005);
    door_closed = 1'b0;
    press_start();
    chk("t4_door_start", {31'd0, mag_on}, 32'd0);
    chk("t4_door_enc", {31'd0, enc_enable}, 32'd1);
    door_closed = 1'b1;
    press_stop();

    // 5: simultaneous start/stop and illegal digit
    key(4'd4);
    chk("t5_digits", digits(), 32'h004);
    startn = 1'b0; stopn = 1'b0; step();
    chk("t5_both", digits(), 32'h000);
    chk("t5_both_mag", {31'd0, mag_on}, 32'd0);
    startn = 1'b1; stopn = 1'b1; step();
    key(4'hA);
    chk("t5_bad_key", digits(), 32'h000);

    // 6: clear during cook
    key(4'd1); key(4'd0);
    press_start();
    chk("t6_cook", {31'd0, mag_on}, 32'd1);
    chk("t6_digits", digits(), 32'h010);
    clear = 1'b1; step();
    clear = 1'b0;
    chk("t6_clr_dig", digits(), 32'h000);
    chk("t6_clr_mag", {31'd0, mag_on}, 32'd0);
    chk("t6_clr_enc", {31'd0, enc_enable}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
